// File: rtl/mem_stage.sv
// mem_stage: data-memory handshake, branch resolve and MEM/WB register.
// Optional ack timeout with sticky error: define MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] Adderout,
    input  logic        zero,
    input  logic [63:0] result_out_alu,
    input  logic [63:0] writedata_out,
    input  logic [4:0]  rd,
    input  logic        Branch,
    input  logic        Memread,
    input  logic        Memtoreg,
    input  logic        MemWrite,
    input  logic        Regwrite,
    input  logic        addermuxselect,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        pcsrc,
    output logic [63:0] branch_target,
    output logic        flush,
    output logic        wb_regwrite,
    output logic        wb_memtoreg,
    output logic [63:0] wb_readdata,
    output logic [63:0] wb_alu_result,
    output logic [4:0]  wb_rd,
    output logic        dmem_err
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic        access;
    logic        timeout_hit;
    logic        bubble;

    logic        wb_regwrite_q;
    logic        wb_memtoreg_q;
    logic [63:0] wb_readdata_q;
    logic [63:0] wb_alu_result_q;
    logic [4:0]  wb_rd_q;

    assign access        = Memread | MemWrite;
    assign dmem_we       = MemWrite;
    assign dmem_addr     = result_out_alu;
    assign dmem_wdata    = writedata_out;
    assign branch_target = Adderout;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       err_q;

    assign timeout_hit = (state_q == S_WAIT) && (cnt_q == TO_LAST) && !dmem_ack;
    assign cnt_d = (state_q == S_WAIT && state_d == S_WAIT) ? cnt_q + 8'd1 : 8'd0;
    assign dmem_err = err_q;

    // Wait-cycle counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | timeout_hit;
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
    assign dmem_err       = 1'b0;
`endif

    // Handshake FSM next state and request; reset drops req at once.
    always_comb begin
        state_d  = state_q;
        dmem_req = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                dmem_req = access;
                if (access && !dmem_ack) state_d = S_WAIT;
            end
            S_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    state_d  = S_IDLE;
                    dmem_req = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!reset) dmem_req = 1'b0;
    end

    assign stall  = dmem_req & ~dmem_ack;
    assign bubble = stall | timeout_hit;
    assign pcsrc  = ~stall & (addermuxselect | (Branch & zero));
    assign flush  = pcsrc;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // MEM/WB register: bubble while stalled, stores never write back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_regwrite_q   <= 1'b0;
            wb_memtoreg_q   <= 1'b0;
            wb_readdata_q   <= 64'd0;
            wb_alu_result_q <= 64'd0;
            wb_rd_q         <= 5'd0;
        end else if (bubble) begin
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_rd_q       <= 5'd0;
        end else begin
            wb_regwrite_q   <= Regwrite & ~MemWrite;
            wb_memtoreg_q   <= Memtoreg;
            wb_rd_q         <= rd;
            wb_alu_result_q <= result_out_alu;
            if (dmem_req && dmem_ack) wb_readdata_q <= dmem_rdata;
        end
    end

    assign wb_regwrite   = wb_regwrite_q;
    assign wb_memtoreg   = wb_memtoreg_q;
    assign wb_readdata   = wb_readdata_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage.
// Timeout cases run when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] Adderout;
    logic        zero;
    logic [63:0] result_out_alu;
    logic [63:0] writedata_out;
    logic [4:0]  rd;
    logic        Branch, Memread, Memtoreg, MemWrite, Regwrite, addermuxselect;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall, pcsrc, flush;
    logic [63:0] branch_target;
    logic        wb_regwrite, wb_memtoreg;
    logic [63:0] wb_readdata, wb_alu_result;
    logic [4:0]  wb_rd;
    logic        dmem_err;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .Adderout(Adderout), .zero(zero),
        .result_out_alu(result_out_alu), .writedata_out(writedata_out),
        .rd(rd), .Branch(Branch), .Memread(Memread), .Memtoreg(Memtoreg),
        .MemWrite(MemWrite), .Regwrite(Regwrite),
        .addermuxselect(addermuxselect), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
        .pcsrc(pcsrc), .branch_target(branch_target), .flush(flush),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_readdata(wb_readdata), .wb_alu_result(wb_alu_result),
        .wb_rd(wb_rd), .dmem_err(dmem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        Adderout = 64'd0; zero = 1'b0; result_out_alu = 64'd0;
        writedata_out = 64'd0; rd = 5'd0; Branch = 1'b0; Memread = 1'b0;
        Memtoreg = 1'b0; MemWrite = 1'b0; Regwrite = 1'b0;
        addermuxselect = 1'b0; dmem_rdata = 64'd0; dmem_ack = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        idle_in();
        reset = 1'b0;
        #3;
        chk("rst_req", 64'(dmem_req), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_wbrw", 64'(wb_regwrite), 64'd0);
        chk("rst_wbrd", 64'(wb_rd), 64'd0);
        chk("rst_wbdata", wb_readdata, 64'd0);
        chk("rst_err", 64'(dmem_err), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // zero-wait load
        Memread = 1; Regwrite = 1; Memtoreg = 1; rd = 5'd5;
        result_out_alu = 64'h100; dmem_rdata = 64'hDEADBEEF; dmem_ack = 1;
        @(negedge clk);
        chk("ld0_stall", 64'(stall), 64'd0);
        chk("ld0_req", 64'(dmem_req), 64'd1);
        chk("ld0_we", 64'(dmem_we), 64'd0);
        chk("ld0_addr", dmem_addr, 64'h100);
        step();
        chk("ld0_data", wb_readdata, 64'hDEADBEEF);
        chk("ld0_rd", 64'(wb_rd), 64'd5);
        chk("ld0_rw", 64'(wb_regwrite), 64'd1);
        chk("ld0_m2r", 64'(wb_memtoreg), 64'd1);
        chk("ld0_alu", wb_alu_result, 64'h100);
        idle_in();

        // store acked after 3 cycles, Regwrite set but must not write back
        MemWrite = 1; Regwrite = 1; writedata_out = 64'h55; rd = 5'd7;
        result_out_alu = 64'h200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("st_stall", 64'(stall), 64'd1);
            chk("st_we", 64'(dmem_we), 64'd1);
            chk("st_wdata", dmem_wdata, 64'h55);
            step();
            chk("st_bub_rw", 64'(wb_regwrite), 64'd0);
            chk("st_bub_rd", 64'(wb_rd), 64'd0);
            chk("st_hold", wb_readdata, 64'hDEADBEEF);
        end
        dmem_ack = 1; dmem_rdata = 64'h1234;
        @(negedge clk);
        chk("st_ack_stall", 64'(stall), 64'd0);
        chk("st_ack_req", 64'(dmem_req), 64'd1);
        step();
        chk("st_rw", 64'(wb_regwrite), 64'd0);
        chk("st_rd", 64'(wb_rd), 64'd7);
        chk("st_data", wb_readdata, 64'h1234);
        idle_in();

        // stray ack without request
        dmem_ack = 1; dmem_rdata = 64'hBAD;
        @(negedge clk);
        chk("stray_req", 64'(dmem_req), 64'd0);
        chk("stray_stall", 64'(stall), 64'd0);
        step();
        chk("stray_data", wb_readdata, 64'h1234);
        idle_in();

        // branches
        Branch = 1; zero = 1; Adderout = 64'h40;
        #1;
        chk("br_pcsrc", 64'(pcsrc), 64'd1);
        chk("br_flush", 64'(flush), 64'd1);
        chk("br_tgt", branch_target, 64'h40);
        zero = 0;
        #1;
        chk("br_nt", 64'(pcsrc), 64'd0);
        addermuxselect = 1;
        #1;
        chk("jmp_pcsrc", 64'(pcsrc), 64'd1);
        Memread = 1;
        #1;
        chk("jmp_stalled", 64'(pcsrc), 64'd0);
        dmem_ack = 1;
        #1;
        chk("jmp_ack", 64'(pcsrc), 64'd1);
        step();
        idle_in();
        #1;
        chk("idle_pcsrc", 64'(pcsrc), 64'd0);

        // reset two cycles into a load
        Memread = 1; Regwrite = 1; rd = 5'd9; result_out_alu = 64'h300;
        step();
        step();
        chk("rw_stall", 64'(stall), 64'd1);
        reset = 1'b0;
        #1;
        chk("rw_req", 64'(dmem_req), 64'd0);
        chk("rw_stall0", 64'(stall), 64'd0);
        chk("rw_data", wb_readdata, 64'd0);
        chk("rw_alu", wb_alu_result, 64'd0);
        chk("rw_rd", 64'(wb_rd), 64'd0);
        Memread = 0; Regwrite = 0;
        @(negedge clk);
        reset = 1'b1;
        dmem_ack = 1; dmem_rdata = 64'hABCD;
        #1;
        chk("late_req", 64'(dmem_req), 64'd0);
        step();
        chk("late_data", wb_readdata, 64'd0);
        dmem_ack = 0;
        #1;
        chk("idle_req", 64'(dmem_req), 64'd0);

`ifdef MEM_TIMEOUT_EN
        Memread = 1; Regwrite = 1; rd = 5'd3;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
        chk("to_cycles", 64'(n), 64'd16);
        chk("to_req", 64'(dmem_req), 64'd0);
        step();
        chk("to_err", 64'(dmem_err), 64'd1);
        chk("to_bub", 64'(wb_regwrite), 64'd0);
        idle_in();
        Memread = 1; dmem_ack = 1; dmem_rdata = 64'h77;
        step();
        idle_in();
        chk("to_err_hold", 64'(dmem_err), 64'd1);
        chk("to_ld_data", wb_readdata, 64'h77);
        reset = 1'b0;
        #1;
        chk("to_err_rst", 64'(dmem_err), 64'd0);
        reset = 1'b1;
`else
        Memread = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall) n++;
        end
        chk("wait_cycles", 64'(n), 64'd20);
        chk("wait_err", 64'(dmem_err), 64'd0);
        dmem_ack = 1; dmem_rdata = 64'h99;
        step();
        idle_in();
        chk("wait_data", wb_readdata, 64'h99);
        #1;
        chk("wait_done", 64'(dmem_req), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 64-bit five-stage pipeline. Consumes the EX/MEM pipeline register outputs, runs the data-memory request/acknowledge handshake, resolves branches, and registers results into the MEM/WB boundary. Stalls the upstream pipeline while a load or store waits on memory.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: ack wait limit, in cycles, used only with MEM_TIMEOUT_EN; range 2..255.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- Adderout  in  64  branch target from EX/MEM.
- zero  in  1  ALU zero flag.
- result_out_alu  in  64  ALU result; also the data-memory address.
- writedata_out  in  64  store data.
- rd  in  5  destination register.
- Branch, Memread, Memtoreg, MemWrite, Regwrite, addermuxselect  in  1 each  control bits from EX/MEM.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  64  equals result_out_alu.
- dmem_wdata  out  64  equals writedata_out.
- dmem_rdata  in  64  load data, valid when dmem_ack = 1.
- dmem_ack  in  1  one-cycle completion strobe.
- stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM.
- pcsrc  out  1  branch taken; selects branch_target.
- branch_target  out  64  equals Adderout.
- flush  out  1  flush to IF/ID, ID/EX and EX/MEM; equals pcsrc.
- wb_regwrite, wb_memtoreg  out  1  registered controls.
- wb_readdata, wb_alu_result  out  64  registered load data and ALU result.
- wb_rd  out  5  registered destination register.
- dmem_err  out  1  sticky timeout flag.

## Operation
- access = Memread | MemWrite. If both bits are set, the operation is a store.
- FSM states:
  - IDLE → WAIT when access & !dmem_ack.
  - IDLE stays in IDLE when there is no access, or when ack arrives in the same cycle (zero-wait memory).
  - WAIT → IDLE on dmem_ack.
- dmem_req = access in IDLE, and 1 in WAIT. dmem_we = MemWrite. Address and data pass through combinationally. Inputs are stable while stall = 1.
- stall = dmem_req & !dmem_ack. Stall is released in the ack cycle.
- Branch taken: pcsrc = !stall & (addermuxselect | (Branch & zero)).
- MEM/WB register on each edge:
  - If stall = 1: load a bubble (wb_regwrite = 0, wb_memtoreg = 0, wb_rd = 0). The data fields hold their previous values.
  - Otherwise: capture Regwrite, Memtoreg, rd and result_out_alu. wb_readdata captures dmem_rdata when dmem_ack = 1, and holds otherwise.
- A store never writes back, regardless of the Regwrite input.

## Timing
- Reset values: state IDLE; all wb_* outputs 0; dmem_err 0; timeout counter 0.
- Combinational outputs follow their inputs: dmem_req, stall, pcsrc and flush are 0 whenever no access or branch is present.
- Zero-wait access: req and ack in cycle N; result visible on wb_* after edge N+1; no stall.
- An ack arriving k cycles after the request gives k stall cycles.
- dmem_ack while dmem_req = 0 is ignored.
- Reset asserted mid-WAIT returns to IDLE and drops req immediately. The outstanding ack is discarded.
- Branch resolution adds no latency: pcsrc and flush take effect in the same cycle the branch occupies MEM.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter increments each cycle in WAIT and clears on leaving WAIT.
  - When the count reaches TIMEOUT_CYCLES−1 without ack: the FSM returns to IDLE, dmem_req drops, stall releases, a bubble enters MEM/WB, and dmem_err is set. dmem_err clears only on reset.
- MEM_TIMEOUT_EN undefined:
  - No counter is built. WAIT persists until ack; dmem_err is tied to 0.

## Test plan
- Load with zero-wait ack: Memread = 1, Regwrite = 1, Memtoreg = 1, rd = 5, addr 0x100, dmem_rdata = 0xDEADBEEF, ack in the same cycle → stall never 1; next edge wb_readdata = 0xDEADBEEF, wb_rd = 5, wb_regwrite = 1.
- Store with ack after 3 cycles: MemWrite = 1, writedata_out = 0x55 → dmem_we = 1, stall = 1 for exactly 3 cycles, three bubbles enter MEM/WB, wb_regwrite stays 0 throughout.
- Branch: Branch = 1, zero = 1, Adderout = 0x40 → pcsrc = flush = 1, branch_target = 0x40 in the same cycle. With zero = 0 → pcsrc = 0. With addermuxselect = 1 → pcsrc = 1 regardless of zero.
- Reset mid-WAIT: assert reset two cycles into a load → dmem_req and stall drop asynchronously; wb_* = 0; state IDLE; a late ack has no effect.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 16: load with no ack → stall for 16 cycles, then dmem_req drops, dmem_err = 1 and stays 1 after the following normal accesses, until reset.
